// File: rtl/exu_pkg.sv
// exu_pkg: shared definitions for the execute/memory unit.
//   - alu_op_t and the ALU operation encodings
//   - RV32I-subset opcode constants
//   - alu_op_from_f3: maps funct3 to an ALU op for R/I-type arithmetic
package exu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_XOR = 3'b100;
  localparam alu_op_t ALU_SLL = 3'b101;
  localparam alu_op_t ALU_SRL = 3'b110;
  localparam alu_op_t ALU_SLT = 3'b111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // funct3 3'b011 (SLTU) is not supported; it falls back to ADD and the
  // caller is responsible for suppressing reg_write.
  function automatic alu_op_t alu_op_from_f3(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/exu_alu.sv
// exu_alu: purely combinational 32-bit ALU.
// Ports:
//   op  - ALU operation (exu_pkg encoding)
//   a   - operand A
//   b   - operand B (b[4:0] is the shift amount)
//   y   - result; arithmetic wraps, SLT is a signed compare giving 0/1
module exu_alu
  import exu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  alu_op_t                   op,
  input  logic signed [DATA_W-1:0]  a,
  input  logic signed [DATA_W-1:0]  b,
  output logic signed [DATA_W-1:0]  y
);

  logic [4:0] shamt;
  logic [DATA_W-1:0] a_u;

  assign shamt = b[4:0];
  assign a_u   = a;

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_XOR: y = a ^ b;
      ALU_SLL: y = a << shamt;
      ALU_SRL: y = $signed(a_u >> shamt);
      ALU_SLT: y = (a < b) ? DATA_W'(1) : '0;
      default: y = a + b;
    endcase
  end

endmodule

// File: rtl/rv_exec_mem_unit.sv
// rv_exec_mem_unit: instruction-control decode, ALU with operand select and
// a word-addressed data memory for the single-cycle RV32I-subset core.
// Ports:
//   clk, reset            - store clock; async active-high reset (clears memory)
//   opcode/funct3/funct7  - instruction fields
//   rs1_data, rs2_data    - register operands (rs2_data is also store data)
//   imm                   - sign-extended immediate
//   reg_write, mem_read, mem_write, branch, branch_taken, alu_op - decode outputs
//   alu_result            - ALU output / memory byte address
//   mem_rdata, wb_data    - loaded word and write-back value
//   misalign              - misaligned access flag
// Build option: define EXU_MISALIGN_CHK_EN to flag misaligned loads/stores,
// block misaligned stores and return 0 for misaligned loads. Without it the
// low address bits are ignored and misalign is tied 0.
module rv_exec_mem_unit
  import exu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        branch,
  output logic        branch_taken,
  output alu_op_t     alu_op,
  output logic [31:0] alu_result,
  output logic [31:0] mem_rdata,
  output logic [31:0] wb_data,
  output logic        misalign
);

  logic signed [31:0] op_a;
  logic signed [31:0] op_b;
  logic signed [31:0] alu_y;
  logic               use_imm;
  logic [AW-1:0]      word_idx;
  logic               wr_en;
  logic               rd_en;
  logic [31:0]        mem [DEPTH];

  always_comb begin
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    alu_op    = ALU_ADD;
    case (opcode)
      OP_R: begin
        if (funct3 != 3'b011) begin
          reg_write = 1'b1;
          alu_op    = (funct3 == 3'b000 && funct7[5]) ? ALU_SUB : alu_op_from_f3(funct3);
        end
      end
      OP_I: begin
        if (funct3 != 3'b011) begin
          reg_write = 1'b1;
          alu_op    = alu_op_from_f3(funct3);
        end
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          reg_write = 1'b1;
          mem_read  = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) mem_write = 1'b1;
      end
      OP_BRANCH: begin
        if (funct3 == 3'b000 || funct3 == 3'b001) begin
          branch = 1'b1;
          alu_op = ALU_SUB;
        end
      end
      default: ;
    endcase
  end

  assign use_imm = (opcode == OP_I) || (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign op_a    = $signed(rs1_data);
  assign op_b    = use_imm ? $signed(imm) : $signed(rs2_data);

  exu_alu #(.DATA_W(32)) u_alu (
    .op (alu_op),
    .a  (op_a),
    .b  (op_b),
    .y  (alu_y)
  );

  assign alu_result   = alu_y;
  assign branch_taken = branch & ((rs1_data == rs2_data) ^ funct3[0]);

  // Upper address bits are dropped, so addresses alias modulo DEPTH words.
  assign word_idx = alu_result[AW+1:2];

`ifdef EXU_MISALIGN_CHK_EN
  assign misalign = (mem_read | mem_write) & (alu_result[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  logic unused_bits;
  assign unused_bits = ^{funct7[6], funct7[4:0], alu_result[31:AW+2], alu_result[1:0]};

  assign wr_en = mem_write & ~misalign;
  assign rd_en = mem_read & ~misalign & ~reset;

  // Reset clears the whole array, so a store racing a reset is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[word_idx] <= rs2_data;
    end
  end

  assign mem_rdata = rd_en ? mem[word_idx] : '0;
  // While reset is held the loaded word is forced 0, so write-back shows the ALU.
  assign wb_data   = (mem_read & ~reset) ? mem_rdata : alu_result;

endmodule

// File: tb/tb_rv_exec_mem_unit.sv
module tb_rv_exec_mem_unit;
  import exu_pkg::*;

  logic        clk;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        branch_taken;
  alu_op_t     alu_op;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] wb_data;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  rv_exec_mem_unit #(.DEPTH(256), .AW(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .opcode       (opcode),
    .funct3       (funct3),
    .funct7       (funct7),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .imm          (imm),
    .reg_write    (reg_write),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .branch       (branch),
    .branch_taken (branch_taken),
    .alu_op       (alu_op),
    .alu_result   (alu_result),
    .mem_rdata    (mem_rdata),
    .wb_data      (wb_data),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "simulation time limit exceeded");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] im);
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
    rs1_data = a;
    rs2_data = b;
    imm      = im;
  endtask

  // Each step drives on the falling edge and samples 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    instr(OP_LOAD, 3'b010, 7'd0, 32'h100, 32'h0, 32'h4);
    #3;
    check("rst_mem_read", {31'd0, mem_read}, 32'd1);
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_wb_alu", wb_data, 32'h104);
    step();
    reset = 1'b0;

    // R-type ADD / SUB
    instr(OP_R, 3'b000, 7'b0000000, 32'd7, 32'd5, 32'd100);
    #1;
    check("add_result", alu_result, 32'd12);
    check("add_reg_write", {31'd0, reg_write}, 32'd1);
    check("add_wb", wb_data, 32'd12);
    check("add_op", {29'd0, alu_op}, {29'd0, ALU_ADD});
    step();
    instr(OP_R, 3'b000, 7'b0100000, 32'd7, 32'd5, 32'd100);
    #1;
    check("sub_result", alu_result, 32'd2);
    check("sub_op", {29'd0, alu_op}, {29'd0, ALU_SUB});

    // I-type SLT / SLL (rs2 chosen so a wrong operand select changes the answer)
    step();
    instr(OP_I, 3'b010, 7'd0, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1);
    #1;
    check("slti_neg", alu_result, 32'd1);
    check("slti_reg_write", {31'd0, reg_write}, 32'd1);
    step();
    instr(OP_I, 3'b010, 7'd0, 32'd5, 32'd9, 32'd1);
    #1;
    check("slti_pos", alu_result, 32'd0);
    step();
    instr(OP_I, 3'b001, 7'd0, 32'h8000_0003, 32'd0, 32'd33);
    #1;
    check("slli_33", alu_result, 32'h0000_0006);
    step();
    instr(OP_I, 3'b101, 7'b0100000, 32'h8000_0000, 32'd0, 32'd4);
    #1;
    check("srli_logical", alu_result, 32'h0800_0000);
    step();
    instr(OP_R, 3'b100, 7'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0);
    #1;
    check("xor", alu_result, 32'h0FF0_0FF0);

    // SW then LW
    step();
    instr(OP_STORE, 3'b010, 7'd0, 32'h100, 32'hDEAD_BEEF, 32'd4);
    #1;
    check("sw_addr", alu_result, 32'h104);
    check("sw_mem_write", {31'd0, mem_write}, 32'd1);
    check("sw_reg_write", {31'd0, reg_write}, 32'd0);
    check("sw_rdata_zero", mem_rdata, 32'h0);
    step();
    instr(OP_STORE, 3'b010, 7'd0, 32'h100, 32'h1111_1111, 32'd8);
    step();
    instr(OP_LOAD, 3'b010, 7'd0, 32'h100, 32'h0, 32'd4);
    #1;
    check("lw_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("lw_wb", wb_data, 32'hDEAD_BEEF);
    check("lw_mem_read", {31'd0, mem_read}, 32'd1);
    step();
    instr(OP_LOAD, 3'b010, 7'd0, 32'h500, 32'h0, 32'd8);
    #1;
    check("lw_alias", mem_rdata, 32'h1111_1111);
    check("lw_alias_wb", wb_data, 32'h1111_1111);

    // Branches
    step();
    instr(OP_BRANCH, 3'b000, 7'd0, 32'd9, 32'd9, 32'd100);
    #1;
    check("beq_taken", {31'd0, branch_taken}, 32'd1);
    check("beq_branch", {31'd0, branch}, 32'd1);
    check("beq_op", {29'd0, alu_op}, {29'd0, ALU_SUB});
    check("beq_reg_write", {31'd0, reg_write}, 32'd0);
    step();
    instr(OP_BRANCH, 3'b001, 7'd0, 32'd9, 32'd9, 32'd100);
    #1;
    check("bne_not_taken", {31'd0, branch_taken}, 32'd0);
    check("bne_op", {29'd0, alu_op}, {29'd0, ALU_SUB});
    step();
    instr(OP_BRANCH, 3'b001, 7'd0, 32'd9, 32'd4, 32'd100);
    #1;
    check("bne_taken", {31'd0, branch_taken}, 32'd1);

    // Illegal encodings
    step();
    instr(7'b1111111, 3'b010, 7'd0, 32'd3, 32'd4, 32'd5);
    #1;
    check("ill_strobes", {27'd0, reg_write, mem_read, mem_write, branch, branch_taken}, 32'd0);
    check("ill_op", {29'd0, alu_op}, {29'd0, ALU_ADD});
    step();
    instr(OP_R, 3'b011, 7'd0, 32'd3, 32'd4, 32'd5);
    #1;
    check("r011_reg_write", {31'd0, reg_write}, 32'd0);
    step();
    instr(OP_LOAD, 3'b000, 7'd0, 32'h100, 32'd0, 32'd4);
    #1;
    check("lb_unsupported", {30'd0, mem_read, reg_write}, 32'd0);

    // Reset pulse between clock edges clears memory
    step();
    instr(OP_LOAD, 3'b010, 7'd0, 32'h100, 32'h0, 32'd4);
    #1;
    check("pre_rst_rdata", mem_rdata, 32'hDEAD_BEEF);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_rdata", mem_rdata, 32'h0);
    check("mid_rst_wb", wb_data, 32'h104);
    check("mid_rst_mem_read", {31'd0, mem_read}, 32'd1);
    #3 reset = 1'b0;
    #1;
    check("post_rst_rdata", mem_rdata, 32'h0);
    check("post_rst_wb", wb_data, 32'h0);

    // Store held while reset is asserted is dropped
    step();
    reset = 1'b1;
    instr(OP_STORE, 3'b010, 7'd0, 32'h100, 32'h5555_AAAA, 32'd12);
    step();
    instr(OP_LOAD, 3'b010, 7'd0, 32'h100, 32'h0, 32'd12);
    reset = 1'b0;
    #1;
    check("store_in_rst", mem_rdata, 32'h0);

    // Misaligned store
    step();
    instr(OP_STORE, 3'b010, 7'd0, 32'h100, 32'h1234_5678, 32'd0);
    step();
    instr(OP_STORE, 3'b010, 7'd0, 32'h100, 32'hA5A5_A5A5, 32'd2);
    #1;
`ifdef EXU_MISALIGN_CHK_EN
    check("sw_misalign", {31'd0, misalign}, 32'd1);
`else
    check("sw_misalign", {31'd0, misalign}, 32'd0);
`endif
    step();
    instr(OP_LOAD, 3'b010, 7'd0, 32'h100, 32'h0, 32'd0);
    #1;
    check("lw_aligned_misalign", {31'd0, misalign}, 32'd0);
`ifdef EXU_MISALIGN_CHK_EN
    check("misalign_word", mem_rdata, 32'h1234_5678);
`else
    check("misalign_word", mem_rdata, 32'hA5A5_A5A5);
`endif
    step();
    instr(OP_LOAD, 3'b010, 7'd0, 32'h100, 32'h0, 32'd1);
    #1;
`ifdef EXU_MISALIGN_CHK_EN
    check("lw_misalign_rdata", mem_rdata, 32'h0);
`else
    check("lw_misalign_rdata", mem_rdata, 32'hA5A5_A5A5);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
